// File: rtl/regfile_writer.sv
// 32 x 16-bit register file write port with a valid/ready write handshake and a
// sequential clear engine that zeroes one register per cycle.
module regfile_writer #(
  parameter int ZERO_R0 = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [4:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        clr_req,
  output logic        busy,
  output logic        clr_done,
  output logic [15:0] r00,
  output logic [15:0] r01,
  output logic [15:0] r02,
  output logic [15:0] r03,
  output logic [15:0] r04,
  output logic [15:0] r05,
  output logic [15:0] r06,
  output logic [15:0] r07,
  output logic [15:0] r08,
  output logic [15:0] r09,
  output logic [15:0] r10,
  output logic [15:0] r11,
  output logic [15:0] r12,
  output logic [15:0] r13,
  output logic [15:0] r14,
  output logic [15:0] r15,
  output logic [15:0] r16,
  output logic [15:0] r17,
  output logic [15:0] r18,
  output logic [15:0] r19,
  output logic [15:0] r20,
  output logic [15:0] r21,
  output logic [15:0] r22,
  output logic [15:0] r23,
  output logic [15:0] r24,
  output logic [15:0] r25,
  output logic [15:0] r26,
  output logic [15:0] r27,
  output logic [15:0] r28,
  output logic [15:0] r29,
  output logic [15:0] r30,
  output logic [15:0] r31
);

  localparam int DATA_W = 16;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e            state_q, state_d;
  logic [4:0]        clr_cnt_q, clr_cnt_d;
  logic              clr_done_q, clr_done_d;
  logic [DATA_W-1:0] regs_q [32];
  logic [DATA_W-1:0] regs_d [32];
  logic              wr_fire;

  assign wr_ready = (state_q == IDLE) && !reset;
  assign wr_fire  = wr_valid && wr_ready;
  assign busy     = (state_q == CLEAR);
  assign clr_done = clr_done_q;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    clr_done_d = 1'b0;
    regs_d     = regs_q;
    case (state_q)
      IDLE: begin
        // A write coinciding with clr_req still commits; the clear wipes it later.
        if (wr_fire) regs_d[wr_addr] = wr_data;
        if (clr_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        regs_d[clr_cnt_q] = '0;
        clr_cnt_d         = clr_cnt_q + 5'd1;
        if (clr_cnt_q == 5'd31) begin
          state_d    = IDLE;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (ZERO_R0 != 0) regs_d[0] = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      clr_cnt_q  <= '0;
      clr_done_q <= 1'b0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_done_q <= clr_done_d;
      regs_q     <= regs_d;
    end
  end

  assign r00 = regs_q[0];
  assign r01 = regs_q[1];
  assign r02 = regs_q[2];
  assign r03 = regs_q[3];
  assign r04 = regs_q[4];
  assign r05 = regs_q[5];
  assign r06 = regs_q[6];
  assign r07 = regs_q[7];
  assign r08 = regs_q[8];
  assign r09 = regs_q[9];
  assign r10 = regs_q[10];
  assign r11 = regs_q[11];
  assign r12 = regs_q[12];
  assign r13 = regs_q[13];
  assign r14 = regs_q[14];
  assign r15 = regs_q[15];
  assign r16 = regs_q[16];
  assign r17 = regs_q[17];
  assign r18 = regs_q[18];
  assign r19 = regs_q[19];
  assign r20 = regs_q[20];
  assign r21 = regs_q[21];
  assign r22 = regs_q[22];
  assign r23 = regs_q[23];
  assign r24 = regs_q[24];
  assign r25 = regs_q[25];
  assign r26 = regs_q[26];
  assign r27 = regs_q[27];
  assign r28 = regs_q[28];
  assign r29 = regs_q[29];
  assign r30 = regs_q[30];
  assign r31 = regs_q[31];

endmodule

// File: tb/tb_regfile_writer.sv
// Directed bench for regfile_writer: a default instance and a ZERO_R0=1 instance
// share all inputs and are checked against one register model and a write scoreboard.
module tb_regfile_writer;

  typedef struct packed {
    logic [4:0]  a;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        clr_req;
  logic        wr_ready, busy, clr_done;
  logic        z_wr_ready, z_busy, z_clr_done;
  logic [15:0] ro [32];
  logic [15:0] zo [32];

  logic [15:0] model [32];
  wr_t         sb_q [$];
  int          errors = 0;
  int          checks = 0;
  int          last_wait = 0;

  always #5 clk = ~clk;

  regfile_writer #(.ZERO_R0(0)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req), .busy(busy), .clr_done(clr_done),
    .r00(ro[0]),  .r01(ro[1]),  .r02(ro[2]),  .r03(ro[3]),  .r04(ro[4]),  .r05(ro[5]),
    .r06(ro[6]),  .r07(ro[7]),  .r08(ro[8]),  .r09(ro[9]),  .r10(ro[10]), .r11(ro[11]),
    .r12(ro[12]), .r13(ro[13]), .r14(ro[14]), .r15(ro[15]), .r16(ro[16]), .r17(ro[17]),
    .r18(ro[18]), .r19(ro[19]), .r20(ro[20]), .r21(ro[21]), .r22(ro[22]), .r23(ro[23]),
    .r24(ro[24]), .r25(ro[25]), .r26(ro[26]), .r27(ro[27]), .r28(ro[28]), .r29(ro[29]),
    .r30(ro[30]), .r31(ro[31])
  );

  regfile_writer #(.ZERO_R0(1)) dut_z (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(z_wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req), .busy(z_busy), .clr_done(z_clr_done),
    .r00(zo[0]),  .r01(zo[1]),  .r02(zo[2]),  .r03(zo[3]),  .r04(zo[4]),  .r05(zo[5]),
    .r06(zo[6]),  .r07(zo[7]),  .r08(zo[8]),  .r09(zo[9]),  .r10(zo[10]), .r11(zo[11]),
    .r12(zo[12]), .r13(zo[13]), .r14(zo[14]), .r15(zo[15]), .r16(zo[16]), .r17(zo[17]),
    .r18(zo[18]), .r19(zo[19]), .r20(zo[20]), .r21(zo[21]), .r22(zo[22]), .r23(zo[23]),
    .r24(zo[24]), .r25(zo[25]), .r26(zo[26]), .r27(zo[27]), .r28(zo[28]), .r29(zo[29]),
    .r30(zo[30]), .r31(zo[31])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("%s_r%0d", tag, i), ro[i], model[i]);
      check($sformatf("%s_z_r%0d", tag, i), zo[i], (i == 0) ? 16'h0 : model[i]);
    end
  endtask

  task automatic check_ctrl(input string tag, input logic b, input logic r, input logic d);
    check({tag, "_busy"}, busy, b);
    check({tag, "_wr_ready"}, wr_ready, r);
    check({tag, "_clr_done"}, clr_done, d);
    check({tag, "_z_busy"}, z_busy, b);
    check({tag, "_z_wr_ready"}, z_wr_ready, r);
    check({tag, "_z_clr_done"}, z_clr_done, d);
  endtask

  // Issues one write (optionally with clr_req on the same edge); returns #1 after acceptance.
  task automatic do_write(input logic [4:0] a, input logic [15:0] d, input bit clr);
    wr_t e;
    int  n;
    n = 0;
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; clr_req = clr;
    while (wr_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    check("wr_wait_bound", 32'(n < 64), 32'd1);
    check("z_wr_ready_at_accept", z_wr_ready, 1'b1);
    check("pre_write_hold", ro[a], model[a]);
    sb_q.push_back('{a: a, d: d});
    @(posedge clk); #1;
    wr_valid = 1'b0; clr_req = 1'b0;
    model[a] = d;
    e = sb_q.pop_front();
    check("write", ro[e.a], e.d);
    check("z_write", zo[e.a], (e.a == 5'd0) ? 16'h0 : e.d);
  endtask

  task automatic start_clear();
    @(negedge clk);
    clr_req = 1'b1;
    check("idle_before_clear", busy, 1'b0);
    @(posedge clk); #1;
    clr_req = 1'b0;
  endtask

  // Entered #1 after the edge that moved the block into CLEAR.
  task automatic run_clear(input bit hold_wr);
    wr_t e;
    for (int i = 0; i < 32; i++) begin
      check($sformatf("clr%0d_busy", i), busy, 1'b1);
      check($sformatf("clr%0d_wr_ready", i), wr_ready, 1'b0);
      check($sformatf("clr%0d_clr_done", i), clr_done, 1'b0);
      check($sformatf("clr%0d_old", i), ro[i], model[i]);
      check($sformatf("clr%0d_r31_hold", i), ro[31], model[31]);
      if (i == 4) clr_req = 1'b1;
      if (i == 6) clr_req = 1'b0;
      if (hold_wr && i == 3) begin
        wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 16'h5A5A;
        sb_q.push_back('{a: 5'd7, d: 16'h5A5A});
      end
      @(posedge clk); #1;
      model[i] = 16'h0;
      check($sformatf("clr%0d_zero", i), ro[i], 16'h0);
      check($sformatf("clr%0d_z_r00", i), zo[0], 16'h0);
    end
    check_ctrl("clr_end", 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    if (hold_wr) begin
      wr_valid = 1'b0;
      e = sb_q.pop_front();
      model[e.a] = e.d;
      check("held_write", ro[e.a], e.d);
    end
    check_ctrl("clr_after", 1'b0, 1'b1, 1'b0);
    check_all("post_clear");
  endtask

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 16'h0;

    #2;
    check_ctrl("reset", 1'b0, 1'b0, 1'b0);
    check_all("reset");
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check_ctrl("released", 1'b0, 1'b1, 1'b0);

    // Write sweep; first write must be taken on the first edge after release.
    for (int k = 0; k < 32; k++) begin
      do_write(5'(k), 16'h1000 + 16'(k), 1'b0);
      if (k == 0) check("first_write_no_wait", last_wait, 0);
    end
    check_all("sweep");

    do_write(5'd5, 16'hBEEF, 1'b0);
    check_all("isolation");

    start_clear();
    run_clear(1'b0);

    // Collision of write and clr_req, plus a write held through the clear.
    do_write(5'd31, 16'hAAAA, 1'b1);
    run_clear(1'b1);

    do_write(5'd2, 16'h1234, 1'b0);
    do_write(5'd12, 16'h4321, 1'b0);
    do_write(5'd3, 16'h9999, 1'b0);
    start_clear();
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) model[i] = 16'h0;
    check("mid_clear_busy", busy, 1'b1);
    check("mid_clear_r12", ro[12], 16'h4321);
    check("mid_clear_r03", ro[3], 16'h0);
    #1;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) model[i] = 16'h0;
    check_ctrl("async_reset", 1'b0, 1'b0, 1'b0);
    check_all("async_reset");
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check_ctrl("reset_release", 1'b0, 1'b1, 1'b0);
    do_write(5'd3, 16'h0007, 1'b0);
    check("post_reset_no_wait", last_wait, 0);
    check("post_reset_r03", ro[3], 16'h0007);
    check_ctrl("post_reset", 1'b0, 1'b1, 1'b0);

    do_write(5'd0, 16'hFFFF, 1'b0);
    check("zero_r0_main", ro[0], 16'hFFFF);
    check("zero_r0_z", zo[0], 16'h0000);
    @(posedge clk); #1;
    check("zero_r0_z_later", zo[0], 16'h0000);
    check_all("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
